array_mult_structural: RTL and testbench
========================================

// Module: array_mult_structural
// PURPOSE
// - 4x4-bit array multiplier packaged as a TinyTapeout user tile.
// - Two 4-bit operands arrive on ui_in; the 8-bit product leaves on uo_out through one output register.
// - Core is structural: 16 AND-gate partial products summed by a carry-save/ripple array of half/full-adder cells.
// - No behavioural '*' operator anywhere in the datapath.
// PARAMETERS
// - None. Operand width is fixed at 4 bits and product width at 8 bits.
// PORTS
// clk      input   1  system clock, all state on rising edge
// rst_n    input   1  reset, asynchronous assert, active-low
// ena      input   1  tile enable; product register loads only when ena=1
// ui_in    input   8  [7:4]=multiplicand A, [3:0]=multiplier B
// uo_out   output  8  registered product P[7:0]
// uio_in   input   8  [0]=signed-mode select (used only with MULT_SIGNED_EN); others ignored
// uio_out  output  8  tied 8'h00
// uio_oe   output  8  tied 8'h00 (all bidirectional pins are inputs)
// BEHAVIOUR
// - Partial products: pp[i][j] = A[j] & B[i], for i,j in 0..3.
// - Row 0 feeds the array directly.
// - Rows 1..3 are added through 3 rows of adder cells.
// - Each row is 4 cells; the LSB cell of row 1 may be a half adder.
// - Final carries ripple left.
// - Result P = A*B, unsigned; max 15*15 = 225 (8'hE1), so no overflow.
// - Adder cells are separate modules: half_adder (s=a^b, c=a&b) and full_adder (s=a^b^ci, c=maj).
// - Register on each rising clk with ena=1: product_q <= P(ui_in); uo_out = product_q.
// - ena=0: product_q holds its value.
// - Latency: exactly 1 clock from ui_in change to uo_out update. Throughput is one product per cycle.
// - Reset: rst_n=0 asynchronously forces product_q = 8'h00, independent of clk.
// - Reset release is synchronous-safe. The first capture occurs on the first rising clk with rst_n=1 and ena=1.
// - Reset mid-operation: the pending product is discarded; uo_out reads 8'h00 until the next capture.
// - uio_out and uio_oe are constant 0 in all states, including reset.
// - Unused inputs (uio_in[7:1]) have no effect.
// CONFIGURATION
// - MULT_SIGNED_EN defined:
//   - uio_in[0]=1 selects two's-complement mode, using a Baugh-Wooley array.
//   - Sign-row partial products are inverted, with constant 1s injected at columns 4 and 7.
//   - P = sext(A)*sext(B) mod 256. Range is -8..7 per operand.
//   - uio_in[0]=0 gives unsigned mode, identical to the undefined case.
//   - The mode bit is sampled in the same cycle as the operands.
// - MULT_SIGNED_EN undefined:
//   - Unsigned only; uio_in[0] is ignored.
//   - No signed logic is synthesised.
// TESTING
// - Reset: rst_n=0 with ui_in=8'hFF -> uo_out=8'h00 immediately, without waiting for clk.
// - Release rst_n, ena=1, ui_in=8'h35 -> one clk later uo_out=8'h0F (3*5=15).
// - ui_in=8'hFF -> next cycle uo_out=8'hE1.
// - ui_in=8'h0F -> uo_out=8'h00.
// - ui_in=8'hF1 -> uo_out=8'h0F.
// - Exhaustive sweep of all 256 ui_in values, compared against A*B one cycle later.
// - Hold: capture 8'h35, then set ena=0 and ui_in=8'hFF for 3 clks -> uo_out stays 8'h0F.
// - Always: uio_out=uio_oe=8'h00.
// - Assert rst_n=0 mid-stream between clk edges -> uo_out goes 8'h00 at once.
// - Signed (MULT_SIGNED_EN, uio_in[0]=1):
//   - ui_in=8'hFF -> 8'h01 (-1*-1).
//   - ui_in=8'h87 -> 8'hC8 (-8*7=-56).
//   - ui_in=8'h88 -> 8'h40 (64).
//   - Exhaustive signed sweep.

Source files
------------

// File: rtl/array_mult_structural_if.sv
// Operand/product pin bundle of the multiplier tile (TinyTapeout user pin set).
// The master drives operands and enable; the slave (tile) returns product and bidir controls.
interface array_mult_structural_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/array_mult_structural.sv
// Structural 4x4 array multiplier tile; optional Baugh-Wooley signed mode under `MULT_SIGNED_EN.
// Partial products are summed by three ripple rows of half/full-adder cells.

// Purpose: single-bit half adder cell.
// Latency: combinational.
// Backpressure: none.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// Purpose: single-bit full adder cell.
// Latency: combinational.
// Backpressure: none.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic c
);
    assign s = a ^ b ^ ci;
    assign c = (a & b) | (ci & (a ^ b));
endmodule

// Purpose: 4x4 -> 8 bit multiplier tile with registered product.
// Latency: 1 clk from ui_in to uo_out.
// Backpressure: none; ena=0 freezes the product register.
module array_mult_structural (
    input  logic clk,
    input  logic rst_n,
    array_mult_structural_if.slave bus
);
    logic [3:0] a, b;
    logic [3:0] pp0, pp1, pp2, pp3;
    logic       inj;
    logic       unused_uio;
    logic       p7;
    logic [7:0] p;
    logic [7:0] product_q;

    assign a = bus.ui_in[7:4];
    assign b = bus.ui_in[3:0];

`ifdef MULT_SIGNED_EN
    logic sgn;
    logic unused_c7;
    assign sgn        = bus.uio_in[0];
    assign unused_uio = ^bus.uio_in[7:1];
    // Baugh-Wooley: invert partial products that carry exactly one sign bit.
    assign pp0 = (a & {4{b[0]}}) ^ {sgn, 3'b000};
    assign pp1 = (a & {4{b[1]}}) ^ {sgn, 3'b000};
    assign pp2 = (a & {4{b[2]}}) ^ {sgn, 3'b000};
    assign pp3 = (a & {4{b[3]}}) ^ {1'b0, {3{sgn}}};
    assign inj = sgn;
`else
    assign unused_uio = ^bus.uio_in;
    assign pp0 = a & {4{b[0]}};
    assign pp1 = a & {4{b[1]}};
    assign pp2 = a & {4{b[2]}};
    assign pp3 = a & {4{b[3]}};
    assign inj = 1'b0;
`endif

    // Row 1: the empty column-4 slot carries the signed-mode correction constant.
    logic r1s0, r1s1, r1s2, r1s3, r1c0, r1c1, r1c2, r1c3;
    half_adder u_r1_0 (.a(pp0[1]), .b(pp1[0]),            .s(r1s0), .c(r1c0));
    full_adder u_r1_1 (.a(pp0[2]), .b(pp1[1]), .ci(r1c0), .s(r1s1), .c(r1c1));
    full_adder u_r1_2 (.a(pp0[3]), .b(pp1[2]), .ci(r1c1), .s(r1s2), .c(r1c2));
    full_adder u_r1_3 (.a(inj),    .b(pp1[3]), .ci(r1c2), .s(r1s3), .c(r1c3));

    logic r2s0, r2s1, r2s2, r2s3, r2c0, r2c1, r2c2, r2c3;
    half_adder u_r2_0 (.a(r1s1), .b(pp2[0]),            .s(r2s0), .c(r2c0));
    full_adder u_r2_1 (.a(r1s2), .b(pp2[1]), .ci(r2c0), .s(r2s1), .c(r2c1));
    full_adder u_r2_2 (.a(r1s3), .b(pp2[2]), .ci(r2c1), .s(r2s2), .c(r2c2));
    full_adder u_r2_3 (.a(r1c3), .b(pp2[3]), .ci(r2c2), .s(r2s3), .c(r2c3));

    logic r3s0, r3s1, r3s2, r3s3, r3c0, r3c1, r3c2, r3c3;
    half_adder u_r3_0 (.a(r2s1), .b(pp3[0]),            .s(r3s0), .c(r3c0));
    full_adder u_r3_1 (.a(r2s2), .b(pp3[1]), .ci(r3c0), .s(r3s1), .c(r3c1));
    full_adder u_r3_2 (.a(r2s3), .b(pp3[2]), .ci(r3c1), .s(r3s2), .c(r3c2));
    full_adder u_r3_3 (.a(r2c3), .b(pp3[3]), .ci(r3c2), .s(r3s3), .c(r3c3));

`ifdef MULT_SIGNED_EN
    // Column-7 correction constant; its carry falls outside the 8-bit product.
    half_adder u_c7 (.a(r3c3), .b(inj), .s(p7), .c(unused_c7));
`else
    assign p7 = r3c3;
`endif

    assign p = {p7, r3s3, r3s2, r3s1, r3s0, r2s0, r1s0, pp0[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product_q <= 8'h00;
        end else if (bus.ena) begin
            product_q <= p;
        end
    end

    assign bus.uo_out  = product_q;
    assign bus.uio_out = 8'h00;
    assign bus.uio_oe  = 8'h00;
endmodule

// File: tb/tb_array_mult_structural.sv
// Scoreboard bench for array_mult_structural: driver queues expected products,
// monitor pops and compares on every capturing clock edge.
module tb_array_mult_structural;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [7:0] exp_q[$];

    array_mult_structural_if bus();

    array_mult_structural dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, req);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] ui, input logic m);
        logic [3:0] ma, mb;
        logic [7:0] pu;
        logic signed [7:0] ps;
        ma = ui[7:4];
        mb = ui[3:0];
        pu = ma * mb;
        ps = $signed(ma) * $signed(mb);
`ifdef MULT_SIGNED_EN
        return m ? ps : pu;
`else
        return (m === 1'bx) ? ps : pu;
`endif
    endfunction

    task automatic apply(input logic [7:0] ui, input logic [7:0] uio, input logic [7:0] exp_p);
        @(negedge clk);
        bus.ena    = 1'b1;
        bus.ui_in  = ui;
        bus.uio_in = uio;
        exp_q.push_back(exp_p);
    endtask

    // Monitor: a capture happens on any rising edge with rst_n=1 and ena=1.
    initial begin
        logic cap;
        logic [7:0] e;
        forever begin
            @(posedge clk);
            cap = rst_n && bus.ena;
            #1;
            check("uio_out", bus.uio_out, 8'h00);
            check("uio_oe", bus.uio_oe, 8'h00);
            if (cap) begin
                if (exp_q.size() == 0) begin
                    bad++;
                    total++;
                    $display("FAIL scoreboard: capture with empty queue, got %02h expected none", bus.uo_out);
                end else begin
                    e = exp_q.pop_front();
                    check("product", bus.uo_out, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] uio;
        total = 0;
        bad   = 0;
        rst_n      = 1'b1;
        bus.ena    = 1'b0;
        bus.ui_in  = 8'hFF;
        bus.uio_in = 8'h00;

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("reset_async", bus.uo_out, 8'h00);
        check("reset_uio_out", bus.uio_out, 8'h00);
        check("reset_uio_oe", bus.uio_oe, 8'h00);

        @(negedge clk);
        rst_n = 1'b1;
        apply(8'h35, 8'h00, 8'h0F);
        apply(8'hFF, 8'h00, 8'hE1);
        apply(8'h0F, 8'h00, 8'h00);
        apply(8'hF1, 8'h00, 8'h0F);
        apply(8'h00, 8'h00, 8'h00);
        apply(8'h1F, 8'h00, 8'h0F);
        // Upper uio_in bits must be ignored in both builds.
        apply(8'hFF, 8'hFE, 8'hE1);
        apply(8'h77, 8'hAA, 8'h31);

        // Hold with ena=0.
        apply(8'h35, 8'h00, 8'h0F);
        @(negedge clk);
        bus.ena   = 1'b0;
        bus.ui_in = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("hold", bus.uo_out, 8'h0F);
        end

        // Reset mid-stream, between clock edges.
        apply(8'h77, 8'h00, 8'h31);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("reset_mid", bus.uo_out, 8'h00);
        @(negedge clk);
        bus.ena   = 1'b1;
        bus.ui_in = 8'hFF;
        @(posedge clk);
        #1;
        check("reset_held", bus.uo_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        bus.ena = 1'b0;

`ifdef MULT_SIGNED_EN
        apply(8'hFF, 8'h01, 8'h01);
        apply(8'h87, 8'h01, 8'hC8);
        apply(8'h88, 8'h01, 8'h40);
        apply(8'h7F, 8'h01, 8'hF9);
        apply(8'h77, 8'h01, 8'h31);
        apply(8'h88, 8'h00, 8'h40);
        apply(8'h87, 8'h00, 8'h38);
        for (int i = 0; i < 256; i++) begin
            uio = {7'($urandom), 1'b1};
            apply(8'(i), uio, model(8'(i), 1'b1));
        end
`endif

        for (int i = 0; i < 256; i++) begin
            uio = {7'($urandom), 1'b0};
            apply(8'(i), uio, model(8'(i), 1'b0));
        end

        @(negedge clk);
        bus.ena = 1'b0;
        @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
